// File: rtl/decode_stage_pipe.sv
// Decode stage: register file, immediate generation and the ID/EX pipeline register.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle writeback data onto the read ports.
module decode_stage_pipe #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_d,
    input  logic            flush_e,
    input  logic            valid_d,
    input  logic [31:0]     instr_d,
    input  logic [2:0]      imm_src_d,
    input  logic [XLEN-1:0] pc_d,
    input  logic [XLEN-1:0] pc_plus4_d,
    input  logic            reg_write_w,
    input  logic [AW-1:0]   rd_w,
    input  logic [XLEN-1:0] result_w,
    output logic [XLEN-1:0] rd1_e,
    output logic [XLEN-1:0] rd2_e,
    output logic [XLEN-1:0] imm_ext_e,
    output logic [XLEN-1:0] pc_e,
    output logic [XLEN-1:0] pc_plus4_e,
    output logic [AW-1:0]   rs1_e,
    output logic [AW-1:0]   rs2_e,
    output logic [AW-1:0]   rd_e,
    output logic            valid_e
);

    logic [XLEN-1:0] regs [NREGS];
    logic [AW-1:0]   rs1_d, rs2_d, rd_d;
    logic [XLEN-1:0] rd1_d, rd2_d, imm_ext_d;
    logic [31:0]     imm32;
    logic            wr_en;

    assign rs1_d = AW'(instr_d[19:15]);
    assign rs2_d = AW'(instr_d[24:20]);
    assign rd_d  = AW'(instr_d[11:7]);
    assign wr_en = reg_write_w && (rd_w != '0);

    // x0 has no storage write path; reads of it are forced to zero as well.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (wr_en) begin
            regs[rd_w] <= result_w;
        end
    end

    always_comb begin
        rd1_d = regs[rs1_d];
        rd2_d = regs[rs2_d];
`ifdef REGFILE_BYPASS_EN
        if (wr_en && rd_w == rs1_d) rd1_d = result_w;
        if (wr_en && rd_w == rs2_d) rd2_d = result_w;
`endif
        if (rs1_d == '0) rd1_d = '0;
        if (rs2_d == '0) rd2_d = '0;
    end

    always_comb begin
        imm32 = '0;
        case (imm_src_d)
            3'd0: imm32 = {{20{instr_d[31]}}, instr_d[31:20]};
            3'd1: imm32 = {{20{instr_d[31]}}, instr_d[31:25], instr_d[11:7]};
            3'd2: imm32 = {{20{instr_d[31]}}, instr_d[7], instr_d[30:25], instr_d[11:8], 1'b0};
            3'd3: imm32 = {{12{instr_d[31]}}, instr_d[19:12], instr_d[20], instr_d[30:21], 1'b0};
            3'd4: imm32 = {instr_d[31:12], 12'b0};
            default: imm32 = '0;
        endcase
    end

    assign imm_ext_d = XLEN'($signed(imm32));

    always_ff @(posedge clk) begin
        if (rst || flush_e) begin
            rd1_e      <= '0;
            rd2_e      <= '0;
            imm_ext_e  <= '0;
            pc_e       <= '0;
            pc_plus4_e <= '0;
            rs1_e      <= '0;
            rs2_e      <= '0;
            rd_e       <= '0;
            valid_e    <= 1'b0;
        end else if (!stall_d) begin
            rd1_e      <= rd1_d;
            rd2_e      <= rd2_d;
            imm_ext_e  <= imm_ext_d;
            pc_e       <= pc_d;
            pc_plus4_e <= pc_plus4_d;
            rs1_e      <= rs1_d;
            rs2_e      <= rs2_d;
            rd_e       <= rd_d;
            valid_e    <= valid_d;
        end
    end

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Scoreboard bench for decode_stage_pipe: driver pushes predicted ID/EX contents, monitor compares.
module tb_decode_stage_pipe;

    logic        clk = 1'b0;
    logic        rst, stall_d, flush_e, valid_d, reg_write_w;
    logic [31:0] instr_d, pc_d, pc_plus4_d, result_w;
    logic [2:0]  imm_src_d;
    logic [4:0]  rd_w;
    logic [31:0] rd1_e, rd2_e, imm_ext_e, pc_e, pc_plus4_e;
    logic [4:0]  rs1_e, rs2_e, rd_e;
    logic        valid_e;

    always #5 clk = ~clk;

    decode_stage_pipe #(.XLEN(32), .NREGS(32), .AW(5)) dut (
        .clk(clk), .rst(rst), .stall_d(stall_d), .flush_e(flush_e), .valid_d(valid_d),
        .instr_d(instr_d), .imm_src_d(imm_src_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d),
        .reg_write_w(reg_write_w), .rd_w(rd_w), .result_w(result_w),
        .rd1_e(rd1_e), .rd2_e(rd2_e), .imm_ext_e(imm_ext_e), .pc_e(pc_e),
        .pc_plus4_e(pc_plus4_e), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e), .valid_e(valid_e)
    );

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    typedef struct {
        logic [31:0] rd1, rd2, imm, pc, pc4;
        logic [4:0]  rs1, rs2, rd;
        logic        v;
    } exp_t;

    exp_t        q[$];
    exp_t        cur;
    logic [31:0] mregs [32];
    int          n_cmp = 0;
    int          n_err = 0;

    function automatic logic [31:0] ref_read(input logic [4:0] a, input bit we,
                                             input logic [4:0] wa, input logic [31:0] wd);
        if (a == 0) return 32'h0;
        if (BYPASS && we && wa == a) return wd;
        return mregs[a];
    endfunction

    // Immediate built arithmetically from field values rather than bit concatenation.
    function automatic logic [31:0] ref_imm(input logic [31:0] ins, input logic [2:0] fmt);
        longint v;
        longint s = ins[31] ? 1 : 0;
        case (fmt)
            3'd0: v = -s * 2048 + longint'(ins[30:20]);
            3'd1: v = -s * 2048 + longint'(ins[30:25]) * 32 + longint'(ins[11:7]);
            3'd2: v = -s * 4096 + longint'(ins[7]) * 2048 + longint'(ins[30:25]) * 32
                      + longint'(ins[11:8]) * 2;
            3'd3: v = -s * 1048576 + longint'(ins[19:12]) * 4096 + longint'(ins[20]) * 2048
                      + longint'(ins[30:21]) * 2;
            3'd4: v = longint'(ins) & 64'hFFFF_F000;
            default: v = 0;
        endcase
        return v[31:0];
    endfunction

    task automatic drive(input bit r, input bit s, input bit f, input bit v,
                         input logic [31:0] ins, input logic [2:0] fmt, input logic [31:0] pc,
                         input bit we, input logic [4:0] wa, input logic [31:0] wd);
        @(negedge clk);
        rst = r; stall_d = s; flush_e = f; valid_d = v; instr_d = ins; imm_src_d = fmt;
        pc_d = pc; pc_plus4_d = pc + 32'd4; reg_write_w = we; rd_w = wa; result_w = wd;
        if (r) begin
            cur = '{default: 0};
            for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
        end else begin
            if (f) cur = '{default: 0};
            else if (!s) begin
                cur.rd1 = ref_read(ins[19:15], we, wa, wd);
                cur.rd2 = ref_read(ins[24:20], we, wa, wd);
                cur.imm = ref_imm(ins, fmt);
                cur.pc  = pc;
                cur.pc4 = pc + 32'd4;
                cur.rs1 = ins[19:15];
                cur.rs2 = ins[24:20];
                cur.rd  = ins[11:7];
                cur.v   = v;
            end
            if (we && wa != 0) mregs[wa] = wd;
        end
        q.push_back(cur);
    endtask

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("rd1_e", rd1_e, e.rd1);
                chk("rd2_e", rd2_e, e.rd2);
                chk("imm_ext_e", imm_ext_e, e.imm);
                chk("pc_e", pc_e, e.pc);
                chk("pc_plus4_e", pc_plus4_e, e.pc4);
                chk("rs1_e", 32'(rs1_e), 32'(e.rs1));
                chk("rs2_e", 32'(rs2_e), 32'(e.rs2));
                chk("rd_e", 32'(rd_e), 32'(e.rd));
                chk("valid_e", 32'(valid_e), 32'(e.v));
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : driver
        bit r, s, f, we;
        {rst, stall_d, flush_e, valid_d, reg_write_w} = '0;
        instr_d = '0; imm_src_d = '0; pc_d = '0; pc_plus4_d = '0; rd_w = '0; result_w = '0;
        cur = '{default: 0};
        for (int i = 0; i < 32; i++) mregs[i] = 32'h0;

        drive(1, 0, 0, 0, 32'h0, 3'd0, 32'h0, 0, 5'd0, 32'h0);
        drive(0, 0, 0, 1, 32'h0002_8013, 3'd0, 32'h100, 0, 5'd0, 32'h0);          // read x5
        drive(0, 0, 0, 0, 32'h0, 3'd0, 32'h104, 1, 5'd3, 32'hDEAD_BEEF);
        drive(0, 0, 0, 1, 32'hFFF1_8093, 3'd0, 32'h108, 0, 5'd0, 32'h0);          // addi x1,x3,-1
        drive(0, 0, 0, 1, 32'h0003_8113, 3'd0, 32'h10C, 1, 5'd7, 32'h0000_1234);  // same-cycle x7
        drive(0, 0, 0, 1, 32'h0003_8113, 3'd0, 32'h110, 0, 5'd0, 32'h0);
        drive(0, 0, 0, 1, 32'h0071_81B3, 3'd1, 32'h114, 0, 5'd0, 32'h0);
        for (int i = 0; i < 3; i++)
            drive(0, 1, 0, $urandom_range(0, 1), $urandom, 3'($urandom_range(0, 7)), $urandom, 0, 5'd0, 32'h0);
        drive(0, 0, 0, 1, 32'h1234_5037, 3'd4, 32'h200, 0, 5'd0, 32'h0);
        drive(0, 1, 1, 1, 32'hFFF1_8093, 3'd0, 32'h204, 0, 5'd0, 32'h0);          // flush beats stall
        drive(0, 0, 0, 1, 32'h0000_0013, 3'd0, 32'h208, 1, 5'd0, 32'hFFFF_FFFF);  // write x0
        drive(0, 0, 0, 1, 32'h0000_0013, 3'd0, 32'h20C, 0, 5'd0, 32'h0);
        drive(0, 0, 0, 1, 32'hFE00_0EE3, 3'd2, 32'h210, 0, 5'd0, 32'h0);
        drive(0, 0, 0, 1, 32'h8000_006F, 3'd3, 32'h214, 0, 5'd0, 32'h0);

        for (int i = 0; i < 600; i++) begin
            r  = ($urandom_range(0, 99) == 0);
            s  = ($urandom_range(0, 4) == 0);
            f  = ($urandom_range(0, 9) == 0);
            we = ($urandom_range(0, 1) == 1);
            drive(r, s, f, $urandom_range(0, 1), $urandom, 3'($urandom_range(0, 7)), $urandom,
                  we, 5'($urandom_range(0, 31)), $urandom);
        end
        drive(0, 0, 0, 0, 32'h0, 3'd0, 32'h0, 0, 5'd0, 32'h0);

        repeat (3) @(posedge clk);
        #2;
        chk("queue_drained", 32'(q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
